// File: rtl/clock_pkg.sv
// Shared constants for the alarm-clock datapath (seconds, minutes and hours
// stages all count in BCD digits with these limits).
package clock_pkg;

    localparam int SEC_MAX               = 59;
    localparam int DIGIT_ONES_MAX        = 9;
    localparam int DIGIT_TENS_MAX        = 5;
    localparam int TICKS_PER_SEC_DEFAULT = 100_000_000;

    // Width of a counter that must hold 0 .. m-1. A modulus of 1 still needs
    // one bit so the port never collapses to zero width.
    function automatic int cnt_width(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage : clock_pkg

// File: rtl/mod_counter.sv
// Modulo-M up counter with enable. `wrap` flags the enabled cycle on which the
// count rolls from M-1 back to 0, so stages can be chained enable-to-wrap.
module mod_counter
    import clock_pkg::*;
#(
    parameter int M = 10,
    localparam int W = cnt_width(M)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] r_count;
    logic         w_at_last;

    assign w_at_last = (r_count == LAST);
    assign wrap      = en && w_at_last;
    assign count     = r_count;

    // Advance on enable, rolling over at M-1 so the value never leaves 0..M-1.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the asynchronous clear must be the first branch so it wins over
        // any enable condition and takes effect without waiting for a clock.
        if (!reset) begin
            r_count <= '0;
        end else if (en) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + W'(1);
            end
        end
    end

endmodule : mod_counter

// File: rtl/counter_min.sv
// Seconds-to-minute stage: prescales the board clock to a one-second tick,
// counts seconds 00-59 as two BCD digits and emits a one-cycle minute carry
// (zC) when the seconds wrap 59 -> 00. All outputs come straight from flops.
module counter_min
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    output logic       zC,
    output logic       tick,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens
);

    localparam int PRESC_W = cnt_width(TICKS_PER_SEC);

    logic [PRESC_W-1:0] w_presc_count;
    logic               w_presc_wrap;
    logic [3:0]         w_ones_count;
    logic               w_ones_wrap;
    logic [2:0]         w_tens_count;
    logic               w_tens_wrap;
    logic               w_unused_presc;

    logic               r_tick;
    logic               r_zc;

    // Free-running prescaler; its wrap is the once-per-second strobe.
    mod_counter #(.M(TICKS_PER_SEC)) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .count (w_presc_count),
        .wrap  (w_presc_wrap)
    );

    // Seconds units digit, 0..9, advanced once per second.
    mod_counter #(.M(DIGIT_ONES_MAX + 1)) u_ones (
        .clk   (clk),
        .reset (reset),
        .en    (w_presc_wrap),
        .count (w_ones_count),
        .wrap  (w_ones_wrap)
    );

    // Seconds tens digit, 0..5, advanced when the units digit rolls over.
    // Its wrap therefore marks exactly the 59 -> 00 edge.
    mod_counter #(.M(DIGIT_TENS_MAX + 1)) u_tens (
        .clk   (clk),
        .reset (reset),
        .en    (w_ones_wrap),
        .count (w_tens_count),
        .wrap  (w_tens_wrap)
    );

    // The prescaler value itself is not an output; fold it into a sink signal.
    assign w_unused_presc = ^w_presc_count;

    // Register the second and minute strobes so they line up with the digit
    // values updated on the same edge and carry no combinational glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick <= 1'b0;
            r_zc   <= 1'b0;
        end else begin
            r_tick <= w_presc_wrap;
            r_zc   <= w_tens_wrap;
        end
    end

    assign tick     = r_tick;
    assign zC       = r_zc;
    assign sec_ones = w_ones_count;
    assign sec_tens = w_tens_count;

endmodule : counter_min

// File: tb/tb_counter_min.sv
// Self-checking bench for counter_min. Two instances run side by side
// (TICKS_PER_SEC = 4 and = 1) against an arithmetic model driven by the count
// of rising edges since reset was released.
module tb_counter_min;

    logic       clk;
    logic       reset;

    logic       zc4, tick4;
    logic [3:0] ones4;
    logic [2:0] tens4;
    logic       zc1, tick1;
    logic [3:0] ones1;
    logic [2:0] tens1;

    int passed = 0;
    int total  = 0;
    int k      = 0;   // rising edges since reset release
    int zc_pulses   = 0;
    int tick_pulses = 0;

    counter_min #(.TICKS_PER_SEC(4)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .zC       (zc4),
        .tick     (tick4),
        .sec_ones (ones4),
        .sec_tens (tens4)
    );

    counter_min #(.TICKS_PER_SEC(1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .zC       (zc1),
        .tick     (tick1),
        .sec_ones (ones1),
        .sec_tens (tens1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, k);
    endtask

    // Reference model: seconds elapsed = floor(k / N), shown modulo 60.
    function automatic int m_seconds(input int edges, input int n);
        return (edges / n) % 60;
    endfunction

    function automatic logic m_tick(input int edges, input int n);
        return (edges > 0) && (edges % n == 0);
    endfunction

    function automatic logic m_zc(input int edges, input int n);
        return (edges > 0) && (edges % (60 * n) == 0);
    endfunction

    task automatic check_model();
        int s4, s1;
        s4 = m_seconds(k, 4);
        s1 = m_seconds(k, 1);
        check("n4_tick", 32'(tick4), 32'(m_tick(k, 4)));
        check("n4_zc",   32'(zc4),   32'(m_zc(k, 4)));
        check("n4_ones", 32'(ones4), s4 % 10);
        check("n4_tens", 32'(tens4), s4 / 10);
        check("n1_tick", 32'(tick1), 32'(m_tick(k, 1)));
        check("n1_zc",   32'(zc1),   32'(m_zc(k, 1)));
        check("n1_ones", 32'(ones1), s1 % 10);
        check("n1_tens", 32'(tens1), s1 / 10);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_n4_zc"},   32'(zc4),   0);
        check({tag, "_n4_tick"}, 32'(tick4), 0);
        check({tag, "_n4_ones"}, 32'(ones4), 0);
        check({tag, "_n4_tens"}, 32'(tens4), 0);
        check({tag, "_n1_zc"},   32'(zc1),   0);
        check({tag, "_n1_ones"}, 32'(ones1), 0);
        check({tag, "_n1_tens"}, 32'(tens1), 0);
    endtask

    // One rising edge, then compare on the following falling edge.
    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        if (zc4)   zc_pulses++;
        if (tick4) tick_pulses++;
        check_model();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        k = 0;
    endtask

    initial begin
        int n;
        reset = 1'b0;

        // Reset values while held low across an edge.
        #25;
        check_zero("reset");
        release_reset();

        // Long run: digit carry, minute carries at 240/480/..., pulse counts.
        zc_pulses   = 0;
        tick_pulses = 0;
        repeat (2400) step();
        check("n4_zc_pulses",   zc_pulses,   10);
        check("n4_tick_pulses", tick_pulses, 600);

        // Reset during the zC-high cycle after edge 240.
        #3 reset = 1'b0;
        #1 check_zero("pre_mid");
        release_reset();
        repeat (240) step();
        check("mid_zc_high", 32'(zc4), 1);
        #3 reset = 1'b0;
        #1 check_zero("mid_reset");
        release_reset();
        zc_pulses = 0;
        repeat (240) step();
        check("mid_next_zc", 32'(zc4), 1);
        check("mid_zc_count", zc_pulses, 1);

        // Randomised run lengths with asynchronous resets at random offsets.
        repeat (6) begin
            n = int'($urandom_range(1, 500));
            repeat (n) step();
            #($urandom_range(1, 8)) reset = 1'b0;
            #1 check_zero("rand_reset");
            release_reset();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_counter_min
